// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
package uart_frame_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CSUM, ST_ISSUE, ST_DONE, ST_ERR
    } state_t;

    localparam logic [1:0]  ERR_NONE = 2'd0;
    localparam logic [1:0]  ERR_LEN  = 2'd1;
    localparam logic [1:0]  ERR_CSUM = 2'd2;
    localparam logic [1:0]  ERR_TMO  = 2'd3;

    localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
    localparam logic [7:0]  CFG_ADDR_DEF    = 8'hFE;
    localparam logic [12:0] DEFAULT_CPB_DEF = 13'd868;
    localparam logic [12:0] MIN_CPB         = 13'd16;
endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Receiver byte input, register-write port and status of the frame controller.
interface uart_rx_frame_ctrl_if;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic [12:0] clks_per_bit;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    modport master (
        input  rx_done, rx_data, wr_ready,
        output clks_per_bit, wr_valid, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
    );
    modport slave (
        output rx_done, rx_data, wr_ready,
        input  clks_per_bit, wr_valid, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload byte buffer: one write port, one combinational indexed read port.
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [MAX_LEN-1:0][7:0] mem;

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser behind the UART receiver: buffers a payload, validates it, then issues writes.
// UART_FRAME_CSUM_EN adds the trailing XOR checksum byte and its check.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int          MAX_LEN      = 16,
    parameter logic [15:0] TIMEOUT_CLKS = 16'd20000,
    parameter logic [12:0] DEFAULT_CPB  = DEFAULT_CPB_DEF,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter logic [7:0]  CFG_ADDR     = CFG_ADDR_DEF
) (
    input logic clk,
    input logic rst,
    uart_rx_frame_ctrl_if.master bus
);
    localparam int         AW       = $clog2(MAX_LEN);
    localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

    state_t      state, state_nxt;
    logic [1:0]  err_q, err_nxt;
    logic [7:0]  base, len, idx, cfg_lo, rd_data;
    logic [15:0] tmo_cnt;
    logic [12:0] cpb, cfg_val;
    logic [AW-1:0] rd_addr;
    logic        is_cfg, cfg_ok, last_pay, issue_vld, fire, in_frame, tmo_hit;
`ifdef UART_FRAME_CSUM_EN
    logic [7:0]  csum;
`endif

    assign is_cfg    = base == CFG_ADDR;
    // Config frames read buf[1]; byte 0 was captured as it arrived.
    assign rd_addr   = is_cfg ? AW'(1) : idx[AW-1:0];
    assign cfg_val   = {rd_data[4:0], cfg_lo};
    assign cfg_ok    = len == 8'd2 && cfg_val >= MIN_CPB;
    assign last_pay  = idx == len - 8'd1;
    assign issue_vld = rst && state == ST_ISSUE && !is_cfg;
    assign fire      = issue_vld && bus.wr_ready;
    assign in_frame  = state inside {ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CSUM};
    assign tmo_hit   = in_frame && !bus.rx_done && tmo_cnt >= TIMEOUT_CLKS - 16'd1;

    uart_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (state == ST_PAYLOAD && bus.rx_done),
        .waddr (idx[AW-1:0]),
        .wdata (bus.rx_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            err_q <= ERR_NONE;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        case (state)
            ST_IDLE:    if (bus.rx_done && bus.rx_data == SYNC_BYTE) state_nxt = ST_ADDR;
            ST_ADDR:    if (bus.rx_done) state_nxt = ST_LEN;
            ST_LEN:
                if (bus.rx_done) begin
                    if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN8) begin
                        state_nxt = ST_ERR;
                        err_nxt   = ERR_LEN;
                    end else begin
                        state_nxt = ST_PAYLOAD;
                    end
                end
`ifdef UART_FRAME_CSUM_EN
            ST_PAYLOAD: if (bus.rx_done && last_pay) state_nxt = ST_CSUM;
            ST_CSUM:
                if (bus.rx_done) begin
                    if (bus.rx_data != csum) begin
                        state_nxt = ST_ERR;
                        err_nxt   = ERR_CSUM;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
`else
            ST_PAYLOAD: if (bus.rx_done && last_pay) state_nxt = ST_ISSUE;
`endif
            ST_ISSUE:
                if (is_cfg) begin
                    state_nxt = cfg_ok ? ST_DONE : ST_ERR;
                    if (!cfg_ok) err_nxt = ERR_LEN;
                end else if (fire && last_pay) begin
                    state_nxt = ST_DONE;
                end
            ST_DONE:    state_nxt = ST_IDLE;
            ST_ERR:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_nxt = ST_ERR;
            err_nxt   = ERR_TMO;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base    <= 8'd0;
            len     <= 8'd0;
            idx     <= 8'd0;
            cfg_lo  <= 8'd0;
            tmo_cnt <= 16'd0;
            cpb     <= DEFAULT_CPB;
`ifdef UART_FRAME_CSUM_EN
            csum    <= 8'd0;
`endif
        end else begin
            tmo_cnt <= (in_frame && !bus.rx_done) ? tmo_cnt + 16'd1 : 16'd0;
            case (state)
                ST_ADDR: if (bus.rx_done) base <= bus.rx_data;
                ST_LEN: if (bus.rx_done) begin
                    len <= bus.rx_data;
                    idx <= 8'd0;
                end
                ST_PAYLOAD: if (bus.rx_done) begin
                    if (idx == 8'd0) cfg_lo <= bus.rx_data;
                    idx <= last_pay ? 8'd0 : idx + 8'd1;
                end
                ST_ISSUE:
                    if (is_cfg) begin
                        if (cfg_ok) cpb <= cfg_val;
                    end else if (fire) begin
                        idx <= idx + 8'd1;
                    end
                default: ;
            endcase
`ifdef UART_FRAME_CSUM_EN
            if (bus.rx_done) begin
                if (state == ST_ADDR) csum <= bus.rx_data;
                else if (state == ST_LEN || state == ST_PAYLOAD) csum <= csum ^ bus.rx_data;
            end
`endif
        end
    end

    assign bus.wr_valid     = issue_vld;
    assign bus.wr_addr      = issue_vld ? base + idx : 8'd0;
    assign bus.wr_data      = issue_vld ? rd_data : 8'd0;
    assign bus.frame_ok     = rst && state == ST_DONE;
    assign bus.frame_err    = rst && state == ST_ERR;
    assign bus.err_code     = err_q;
    assign bus.busy         = state != ST_IDLE;
    assign bus.clks_per_bit = cpb;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed + randomized frames against a frame-level reference model of the controller.
module tb_uart_rx_frame_ctrl;
    localparam int MAX_LEN = 16;
    localparam int TMO     = 20000;
`ifdef UART_FRAME_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if bus();
    uart_rx_frame_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ok_cnt = 0, err_cnt = 0, ok_cyc = 0, err_cyc = 0, rx_cyc = 0;
    logic [12:0] ok_cpb;
    logic [7:0] wa_q[$], wd_q[$];
    int wc_q[$];
    logic pv = 1'b0, pr = 1'b0, prst = 1'b0;
    logic [7:0] pa = 8'd0, pd = 8'd0;

    logic [7:0]  pay [0:MAX_LEN];
    logic [12:0] model_cpb = 13'd868;
    logic [1:0]  model_err = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample away from the active edge; log handshakes, pulses and hold behaviour.
    always @(negedge clk) begin
        cyc++;
        if (rst && prst && pv && !pr) begin
            check("hold_valid", 32'(bus.wr_valid), 32'd1);
            check("hold_addr", 32'(bus.wr_addr), 32'(pa));
            check("hold_data", 32'(bus.wr_data), 32'(pd));
        end
        if (bus.wr_valid && bus.wr_ready) begin
            wa_q.push_back(bus.wr_addr);
            wd_q.push_back(bus.wr_data);
            wc_q.push_back(cyc);
        end
        if (bus.frame_ok) begin ok_cnt++; ok_cyc = cyc; ok_cpb = bus.clks_per_bit; end
        if (bus.frame_err) begin err_cnt++; err_cyc = cyc; end
        if (bus.rx_done) rx_cyc = cyc;
        pv = bus.wr_valid; pr = bus.wr_ready; pa = bus.wr_addr; pd = bus.wr_data; prst = rst;
    end

    task automatic send_byte(input logic [7:0] b, input bit last);
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        tick();
        bus.rx_done = 1'b0;
        if (!last) repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic run_frame(input logic [7:0] addr, input int len, input bit bad_csum, input bit rdy_hi);
        logic [7:0] cs, ta;
        logic [7:0] ea[$], ed[$];
        logic [12:0] val;
        bit exp_ok, len_bad, done;
        int ok0, err0, n;
        exp_ok  = 1'b1;
        len_bad = (len < 1 || len > MAX_LEN);
        cs = addr ^ 8'(len);
        if (!len_bad) for (int i = 0; i < len; i++) cs ^= pay[i];
        if (len_bad) begin
            exp_ok = 1'b0; model_err = 2'd1;
        end else if (CSUM_EN && bad_csum) begin
            exp_ok = 1'b0; model_err = 2'd2;
        end else if (addr == 8'hFE) begin
            val = {pay[1][4:0], pay[0]};
            if (len == 2 && val >= 13'd16) model_cpb = val;
            else begin exp_ok = 1'b0; model_err = 2'd1; end
        end else begin
            for (int i = 0; i < len; i++) begin
                ta = addr + 8'(i);
                ea.push_back(ta);
                ed.push_back(pay[i]);
            end
        end

        wa_q.delete(); wd_q.delete(); wc_q.delete();
        ok0 = ok_cnt; err0 = err_cnt;
        bus.wr_ready = rdy_hi;
        send_byte(8'hA5, 1'b0);
        send_byte(addr, 1'b0);
        send_byte(8'(len), len_bad || (!CSUM_EN && len == 0));
        if (!len_bad) begin
            for (int i = 0; i < len; i++) send_byte(pay[i], !CSUM_EN && i == len - 1);
            if (CSUM_EN) send_byte(bad_csum ? cs ^ 8'h5A : cs, 1'b1);
        end

        done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (ok_cnt != ok0 || err_cnt != err0) begin done = 1'b1; break; end
            if (!rdy_hi) begin
                bus.wr_ready = 1'($urandom_range(0, 1));
                bus.rx_done  = ($urandom_range(0, 3) == 0);
                bus.rx_data  = 8'hA5;
            end
        end
        bus.rx_done = 1'b0;

        check("frame_end", 32'(done), 32'd1);
        check("ok_pulses", 32'(ok_cnt - ok0), 32'(exp_ok));
        check("err_pulses", 32'(err_cnt - err0), 32'(!exp_ok));
        check("err_code", 32'(bus.err_code), 32'(model_err));
        check("n_writes", 32'(wa_q.size()), 32'(ea.size()));
        n = (wa_q.size() < ea.size()) ? wa_q.size() : ea.size();
        for (int i = 0; i < n; i++) begin
            check("wr_addr", 32'(wa_q[i]), 32'(ea[i]));
            check("wr_data", 32'(wd_q[i]), 32'(ed[i]));
        end
        if (exp_ok) check("cpb_at_ok", 32'(ok_cpb), 32'(model_cpb));
        check("cpb", 32'(bus.clks_per_bit), 32'(model_cpb));
        if (rdy_hi && exp_ok && ea.size() > 0 && wc_q.size() == ea.size()) begin
            check("first_wr_lat", 32'(wc_q[0] - rx_cyc), 32'd1);
            for (int i = 1; i < wc_q.size(); i++)
                check("wr_back2back", 32'(wc_q[i] - wc_q[i-1]), 32'd1);
            check("ok_after_last", 32'(ok_cyc - wc_q[wc_q.size()-1]), 32'd1);
        end
        bus.wr_ready = 1'b0;
        repeat (3) tick();
        check("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bit done;
        int ok0, err0, d, r;
        logic [7:0] a;
        int l;
        bus.rx_done = 1'b0; bus.rx_data = 8'd0; bus.wr_ready = 1'b0;
        for (int i = 0; i <= MAX_LEN; i++) pay[i] = 8'd0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.wr_valid), 32'd0);
        check("rst_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_data", 32'(bus.wr_data), 32'd0);
        check("rst_ok", 32'(bus.frame_ok), 32'd0);
        check("rst_err", 32'(bus.frame_err), 32'd0);
        check("rst_code", 32'(bus.err_code), 32'd0);
        check("rst_cpb", 32'(bus.clks_per_bit), 32'd868);

        pay[0] = 8'h11; pay[1] = 8'h22;
        run_frame(8'h10, 2, 1'b0, 1'b1);
        run_frame(8'h10, 2, 1'b1, 1'b1);
        run_frame(8'h20, 0, 1'b0, 1'b1);
        run_frame(8'h20, MAX_LEN + 1, 1'b0, 1'b1);
        pay[0] = 8'hB2; pay[1] = 8'h01;
        run_frame(8'hFE, 2, 1'b0, 1'b1);
        pay[0] = 8'h05; pay[1] = 8'h00;
        run_frame(8'hFE, 2, 1'b0, 1'b0);

        // Stall inside a frame long enough to trip the idle timeout.
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h30, 1'b1);
        done = 1'b0;
        for (int k = 0; k < TMO + 50; k++) begin
            tick();
            if (err_cnt != err0) begin done = 1'b1; break; end
        end
        model_err = 2'd3;
        d = err_cyc - rx_cyc;
        check("tmo_fired", 32'(done), 32'd1);
        check("tmo_code", 32'(bus.err_code), 32'd3);
        check("tmo_window", 32'(d >= TMO && d <= TMO + 2), 32'd1);
        check("tmo_no_ok", 32'(ok_cnt - ok0), 32'd0);
        for (int i = 0; i < 3; i++) pay[i] = 8'(8'h61 + i);
        run_frame(8'h55, 3, 1'b0, 1'b1);

        pay[0] = 8'hC1; pay[1] = 8'hC2; pay[2] = 8'hC3;
        run_frame(8'hFF, 3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
        run_frame(8'hFD, 4, 1'b0, 1'b0);

        for (int f = 0; f < 20; f++) begin
            r = $urandom_range(0, 7);
            a = (r == 0) ? 8'hFE : (r == 1) ? 8'($urandom_range(8'hF0, 8'hFF)) : 8'($urandom);
            if ($urandom_range(0, 9) == 0) l = $urandom_range(0, 1) ? 0 : MAX_LEN + 1;
            else if (a == 8'hFE) l = $urandom_range(0, 3) == 0 ? 3 : 2;
            else l = $urandom_range(1, MAX_LEN);
            for (int i = 0; i <= MAX_LEN; i++) pay[i] = 8'($urandom);
            run_frame(a, l, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
        end

        // Reset while a write is stalled: nothing further may be issued.
        for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
        pay[0] = 8'hB2; pay[1] = 8'h01;
        run_frame(8'hFE, 2, 1'b0, 1'b1);
        wa_q.delete(); ok0 = ok_cnt; err0 = err_cnt;
        bus.wr_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h40, 1'b0);
        send_byte(8'd4, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(pay[i], !CSUM_EN && i == 3);
        if (CSUM_EN) send_byte(8'h40 ^ 8'd4 ^ pay[0] ^ pay[1] ^ pay[2] ^ pay[3], 1'b1);
        repeat (3) tick();
        check("stall_valid", 32'(bus.wr_valid), 32'd1);
        check("stall_addr", 32'(bus.wr_addr), 32'h40);
        rst = 1'b0;
        bus.wr_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        repeat (5) tick();
        model_cpb = 13'd868; model_err = 2'd0;
        check("rst_no_writes", 32'(wa_q.size()), 32'd0);
        check("rst_no_pulse", 32'((ok_cnt - ok0) + (err_cnt - err0)), 32'd0);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_valid", 32'(bus.wr_valid), 32'd0);
        check("post_rst_code", 32'(bus.err_code), 32'(model_err));
        check("post_rst_cpb", 32'(bus.clks_per_bit), 32'(model_cpb));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
